// File: rtl/csa_arb_pkg.sv
// csa_arb_pkg: definitions shared by the csa_adder_arbiter slice.
//   CNT_W / CNT_MAX : width and saturation value of the optional grant counters
//   ostage_e        : occupancy of the single-entry output stage
//   params_ok()     : legality check for the arbiter parameters
package csa_arb_pkg;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostage_e;

  // The carry-select adder splits the operands in halves, so the width must be even.
  function automatic bit params_ok(int num_req, int in_dw);
    return (num_req >= 2) && (in_dw >= 2) && ((in_dw % 2) == 0);
  endfunction

endpackage

// File: rtl/n_bit_csa_adder.sv
// n_bit_csa_adder: unsigned carry-select adder, sum = in1 + in2 + cin.
//   in1, in2 : DATAWIDTH-bit operands (DATAWIDTH even)
//   cin      : carry-in
//   sum      : DATAWIDTH+1-bit result, MSB is the carry-out
module n_bit_csa_adder #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] in1,
  input  logic [DATAWIDTH-1:0] in2,
  input  logic                 cin,
  output logic [DATAWIDTH:0]   sum
);

  localparam int LO_W = DATAWIDTH / 2;
  localparam int HI_W = DATAWIDTH - LO_W;

  logic [LO_W:0] lo;
  logic [HI_W:0] hi0;
  logic [HI_W:0] hi1;

  assign lo  = {1'b0, in1[LO_W-1:0]} + {1'b0, in2[LO_W-1:0]} + {{LO_W{1'b0}}, cin};

  // Upper half is precomputed for both possible carries; the low-half carry selects.
  assign hi0 = {1'b0, in1[DATAWIDTH-1:LO_W]} + {1'b0, in2[DATAWIDTH-1:LO_W]};
  assign hi1 = hi0 + {{HI_W{1'b0}}, 1'b1};

  assign sum = lo[LO_W] ? {hi1, lo[LO_W-1:0]} : {hi0, lo[LO_W-1:0]};

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   : request vector
//   ptr   : index at which the search starts (wraps NUM_REQ-1 -> 0)
//   en    : when low, no grant is issued
//   grant : one-hot grant (zero when disabled or nothing requested)
//   idx   : encoded index of the first requester found (0 when none)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic [NUM_REQ-1:0] onehot;
  logic               found;
  int                 pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[ID_W'(pos)]) begin
        found               = 1'b1;
        idx                 = ID_W'(pos);
        onehot[ID_W'(pos)]  = 1'b1;
      end
    end
  end

  assign grant = en ? onehot : '0;

endmodule

// File: rtl/csa_adder_arbiter.sv
// csa_adder_arbiter: round-robin share of one n_bit_csa_adder among NUM_REQ
// requesters, with a single-entry registered output stage.
//   clk, rst                        : clock, async active-high reset
//   req_valid/req_ready             : per-requester handshake (ready one-hot or zero)
//   req_in1/req_in2/req_cin         : packed operands, requester i at [i*IN_DATAWIDTH +: IN_DATAWIDTH]
//   rsp_valid/rsp_ready             : output-stage handshake
//   rsp_sum/rsp_id                  : registered sum (with carry-out) and winning index
//   grant_cnt                       : saturating 16-bit grant counters, only with CSA_ARB_STATS_EN
//
// Output stage states:
//   state | meaning
//   EMPTY | no result held, rsp_valid=0
//   FULL  | result held in rsp_sum/rsp_id, rsp_valid=1
module csa_adder_arbiter
  import csa_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int IN_DATAWIDTH  = 8,
  parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*IN_DATAWIDTH-1:0] req_in1,
  input  logic [NUM_REQ*IN_DATAWIDTH-1:0] req_in2,
  input  logic [NUM_REQ-1:0]              req_cin,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [OUT_DATAWIDTH-1:0]        rsp_sum,
  output logic [ID_W-1:0]                 rsp_id
`ifdef CSA_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]        grant_cnt
`endif
);

  if (!params_ok(NUM_REQ, IN_DATAWIDTH)) begin : g_bad_params
    $error("csa_adder_arbiter: NUM_REQ must be >= 2 and IN_DATAWIDTH even");
  end

  ostage_e                 state_q, state_d;
  logic                    can_accept;
  logic                    transfer;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         win_idx;
  logic [ID_W-1:0]         ptr_q;
  logic [IN_DATAWIDTH-1:0] op1, op2;
  logic                    op_cin;
  logic [IN_DATAWIDTH:0]   add_sum;
  logic [OUT_DATAWIDTH-1:0] sum_q;
  logic [ID_W-1:0]         id_q;

  assign can_accept = (state_q == EMPTY) || rsp_ready;

  // Gating with rst keeps requests presented during reset from being acknowledged.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (can_accept & ~rst),
    .grant (grant),
    .idx   (win_idx)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  assign op1    = req_in1[win_idx*IN_DATAWIDTH +: IN_DATAWIDTH];
  assign op2    = req_in2[win_idx*IN_DATAWIDTH +: IN_DATAWIDTH];
  assign op_cin = req_cin[win_idx];

  n_bit_csa_adder #(
    .DATAWIDTH (IN_DATAWIDTH)
  ) u_adder (
    .in1 (op1),
    .in2 (op2),
    .cin (op_cin),
    .sum (add_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (transfer) state_d = FULL;
      FULL: begin
        // Drain and refill in the same cycle stays FULL without a bubble.
        if (transfer)       state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      id_q  <= '0;
      ptr_q <= '0;
    end else if (transfer) begin
      sum_q <= OUT_DATAWIDTH'(add_sum);
      id_q  <= win_idx;
      ptr_q <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

`ifdef CSA_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule
